// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   UART transmitter sitting on the processor data-memory write bus.
//   A store to BASE_ADDR queues dout[7:0] in a small byte FIFO; a frame FSM
//   sends each queued byte as 8N1 (start, 8 data LSB first, stop) on tx.
//   A store to BASE_ADDR+1 with dout[0]=1 clears the sticky overflow flag.
//
// Parameters
//   BASE_ADDR    data register address; status register at BASE_ADDR+1
//   CLKS_PER_BIT clock cycles per serial bit (2..65535)
//   FIFO_DEPTH   byte FIFO depth (power of two, 2..16)
//
// Ports
//   clk_50MHz  in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   addr       in   bus address
//   dout       in   bus write data
//   w          in   bus write strobe
//   rd_data    out  registered status read-back {13'b0, overflow, fifo_full, busy}
//   tx         out  serial line, idle high, registered
//   busy       out  frame in progress or bytes queued
//   fifo_full  out  FIFO holds FIFO_DEPTH bytes
//   overflow   out  sticky: a data write was dropped while full
module mmio_uart_tx #(
  parameter logic [7:0] BASE_ADDR    = 8'hF0,
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic [15:0] dout,
  input  logic        w,
  output logic [15:0] rd_data,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int              PW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = PW + 1;
  localparam logic [7:0]      STAT_ADDR = BASE_ADDR + 8'd1;
  localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;

  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           overflow_q;
  logic [15:0]    rd_data_q;
  logic [7:0]     mem_q [FIFO_DEPTH];

  logic data_wr, push, drop, clr, pop;

  // Only the low byte of a data write is transmitted.
  logic unused_dout;
  assign unused_dout = ^dout[15:8];

  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign fifo_full = (count_q == DEPTH_C);
  assign overflow  = overflow_q;
  assign tx        = tx_q;
  assign rd_data   = rd_data_q;

  // Fullness is judged on the pre-edge count, so a write into a full FIFO
  // is dropped even if the FSM pops in the same cycle.
  assign data_wr = w && (addr == BASE_ADDR);
  assign push    = data_wr && !fifo_full;
  assign drop    = data_wr && fifo_full;
  assign clr     = w && (addr == STAT_ADDR) && dout[0];
  // Pop uses the pre-edge count, so a freshly pushed byte waits one cycle.
  assign pop     = (state_q == IDLE) && (count_q != '0);

  // Storage array carries no reset; emptiness is tracked by the count.
  always_ff @(posedge clk_50MHz) begin
    if (push) mem_q[wr_ptr_q] <= dout[7:0];
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop)     overflow_q <= 1'b1;
      else if (clr) overflow_q <= 1'b0;
      rd_data_q <= (addr == STAT_ADDR) ? {13'b0, overflow_q, fifo_full, busy} : 16'h0000;
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is derived from the next state so the line changes on the same
    // edge as the state and comes straight from a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor's data-memory write bus, directly downstream of the processor's ADDR/DOUT/W registers. Stores to the data address push one byte into a small FIFO; a frame FSM serialises each byte as 8N1 on `tx`. A status register reports busy/full/overflow, and a store to the status address clears the sticky overflow flag.

## Interface
Parameters:
- `BASE_ADDR`, 8'hF0: data register address; status register is `BASE_ADDR+1` (8-bit wrap).
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 4: byte FIFO depth; power of two, 2..16.

Ports:
- `clk_50MHz` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `addr` in 8: bus address, driven from the processor ADDR register.
- `dout` in 16: bus write data, driven from the processor DOUT register.
- `w` in 1: bus write strobe, driven from the processor W register; one write per cycle it is high.
- `rd_data` out 16: registered status read-back.
- `tx` out 1: serial line, idle high.
- `busy` out 1: FSM not IDLE, or FIFO not empty.
- `fifo_full` out 1: FIFO count equals `FIFO_DEPTH`.
- `overflow` out 1: sticky; set by a write dropped while full.

## Operation
- Data write: `w=1` and `addr==BASE_ADDR`.
  - FIFO not full (count before the edge): push `dout[7:0]`; `dout[15:8]` is ignored.
  - FIFO full: drop the byte and set `overflow`. This applies even if a pop happens in the same cycle.
- Status write: `w=1`, `addr==BASE_ADDR+1`, and `dout[0]=1` clears `overflow`. A simultaneous set is impossible because the two addresses differ.
- Other addresses are ignored.
- `rd_data` is registered every cycle:
  - `addr==BASE_ADDR+1`: `{13'b0, overflow, fifo_full, busy}`, sampled from pre-edge values.
  - Any other address: 16'h0000.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo `FIFO_DEPTH`.
  - Count spans 0..`FIFO_DEPTH`.
  - Simultaneous push and pop leaves the count unchanged.
  - No bypass: a byte pushed into an empty FIFO is popped no earlier than the next cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If count>0, pop into an 8-bit shift register, clear the baud counter, and go to START.
  - START: `tx=0` for `CLKS_PER_BIT` cycles, then clear the bit index and go to DATA.
  - DATA: `tx=shift[0]`, sending LSB first. After each `CLKS_PER_BIT` cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles, then go to IDLE.
- Arithmetic widths:
  - Baud counter is 16 bit and counts 0..`CLKS_PER_BIT-1`.
  - Bit index is 3 bit.
  - FIFO pointers are log2(`FIFO_DEPTH`) bits; count is one bit wider.
- `tx` is a registered output and is glitch-free.

## Timing
- Reset values: `tx=1`, `busy=0`, `fifo_full=0`, `overflow=0`, `rd_data=0`, state IDLE, FIFO empty, all counters 0.
- Reset asserted mid-frame aborts immediately and asynchronously. `tx` returns to 1 and FIFO contents are discarded.
- Write latency, for a data write sampled at edge k into an empty FIFO with the FSM in IDLE:
  - `busy=1` after edge k.
  - Pop and START entry at edge k+1, so `tx` falls after edge k+1.
- Frame length: 10·`CLKS_PER_BIT` cycles (START + 8 DATA + STOP).
- Inter-frame gap: exactly one IDLE cycle between frames. The next `tx` fall comes 10·`CLKS_PER_BIT`+1 cycles after the previous fall.
- `fifo_full` and `overflow` update on the edge that changes the count or flag.
- `rd_data` reflects the status one cycle after `addr` presents the status address.

## Test plan
- Reset / idle: assert `reset` mid-frame for 3 cycles → `tx=1` at once; `busy=0`, `fifo_full=0`, `overflow=0`, `rd_data=0` until the next write.
- Single byte, `CLKS_PER_BIT=4`: write 16'h12A5 to 8'hF0 at edge k.
  - `tx` low for cycles k+1..k+4.
  - Data bits 1,0,1,0,0,1,0,1, four cycles each.
  - `tx` high for cycles k+37..k+40; `busy=0` after edge k+41.
  - Upper byte 8'h12 never appears on `tx`.
- Back-to-back: write 8'h00 then 8'hFF on consecutive cycles → second `tx` fall exactly 41 cycles after the first.
- Overflow with `FIFO_DEPTH=4`:
  - Write 6 bytes in 6 consecutive cycles → bytes 1–5 accepted (byte 1 popped at once), byte 6 dropped.
  - `fifo_full=1` and `overflow=1`; only 5 frames are transmitted.
  - Reading 8'hF1 returns 16'h0007.
  - Writing 16'h0001 to 8'hF1 then reading 8'hF1 returns 16'h0003.
- Address decode: writes to 8'hEF, 8'hF2 and 8'h00 → no push, no flag change, `tx` stays 1, and `rd_data` for those addresses reads 0.
- Pointer wrap: 10 single-byte writes spaced one frame apart → 10 correct frames in order, with count never above 1.
